// File: rtl/alu_arbiter.sv
// alu_arbiter
// Arbitrates two requesters onto one shared 8-bit ALU. Each operation walks
// IDLE -> SETUP -> EXEC -> FLAGS -> DONE. Operands and the subtract select are
// latched when the grant is given. The ALU result is captured on EXEC exit.
// The carry and zero flags are captured on FLAGS exit.
//
// Configuration macro: ALU_ARBITER_ROUND_ROBIN_EN
//   defined   : round-robin arbitration; the pointer updates in DONE
//   undefined : fixed priority; requester 0 wins a tie
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_req0/1, i_sub0/1          per-requester request and add/subtract select
//   i_a0/i_b0, i_a1/i_b1        per-requester operands
//   i_bus, i_flag_c, i_flag_z   ALU result bus and flags
//   o_data_a, o_data_b          operands driven to the ALU
//   o_alu_subtract              ALU subtract select
//   o_alu_read_n                active-low ALU result read enable
//   o_alu_read_flags_n          active-low ALU flag read enable
//   o_grant0/1                  requester owns the ALU (one-hot or zero)
//   o_done0/1                   one-cycle result-valid pulse
//   o_result, o_carry, o_zero   last captured result and flags
module alu_arbiter (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_sub0,
    input  logic       i_sub1,
    input  logic [7:0] i_a0,
    input  logic [7:0] i_b0,
    input  logic [7:0] i_a1,
    input  logic [7:0] i_b1,
    input  logic [7:0] i_bus,
    input  logic       i_flag_c,
    input  logic       i_flag_z,
    output logic [7:0] o_data_a,
    output logic [7:0] o_data_b,
    output logic       o_alu_subtract,
    output logic       o_alu_read_n,
    output logic       o_alu_read_flags_n,
    output logic       o_grant0,
    output logic       o_grant1,
    output logic       o_done0,
    output logic       o_done1,
    output logic [7:0] o_result,
    output logic       o_carry,
    output logic       o_zero
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EXEC  = 3'd2,
        ST_FLAGS = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic       owner_reg;          // requester that owns the current operation
    logic       pick1;              // requester 1 wins the arbitration this cycle
    logic [7:0] data_a_reg, data_b_reg, result_reg;
    logic       sub_reg, carry_reg, zero_reg;
    logic       busy, in_done;
    logic [1:0] grant_vec, done_vec;

`ifdef ALU_ARBITER_ROUND_ROBIN_EN
    // prio_reg names the requester that wins the next tie. It points away
    // from the requester that was served last.
    logic prio_reg;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prio_reg <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            prio_reg <= ~owner_reg;
        end
    end

    assign pick1 = i_req1 & (~i_req0 | prio_reg);
`else
    assign pick1 = i_req1 & ~i_req0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (i_req0 | i_req1) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_EXEC;
            ST_EXEC:  state_next = ST_FLAGS;
            ST_FLAGS: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy               = 1'b0;
        in_done            = 1'b0;
        o_alu_read_n       = 1'b1;
        o_alu_read_flags_n = 1'b1;
        case (state_reg)
            ST_SETUP: busy = 1'b1;
            ST_EXEC: begin
                busy         = 1'b1;
                o_alu_read_n = 1'b0;
            end
            ST_FLAGS: begin
                busy               = 1'b1;
                o_alu_read_flags_n = 1'b0;
            end
            ST_DONE: begin
                busy    = 1'b1;
                in_done = 1'b1;
            end
            default: ;
        endcase
    end

    // The grant covers SETUP through DONE. It is derived from the state and the
    // owner, so it cannot outlive the operation or survive a reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign grant_vec[gi] = busy    & (owner_reg == 1'(gi));
            assign done_vec[gi]  = in_done & (owner_reg == 1'(gi));
        end
    endgenerate

    assign o_grant0 = grant_vec[0];
    assign o_grant1 = grant_vec[1];
    assign o_done0  = done_vec[0];
    assign o_done1  = done_vec[1];

    // Datapath: latch at grant, capture result and flags on the read-cycle exits
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            owner_reg  <= 1'b0;
            data_a_reg <= 8'h00;
            data_b_reg <= 8'h00;
            sub_reg    <= 1'b0;
            result_reg <= 8'h00;
            carry_reg  <= 1'b0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_req0 | i_req1) begin
                        owner_reg  <= pick1;
                        data_a_reg <= pick1 ? i_a1 : i_a0;
                        data_b_reg <= pick1 ? i_b1 : i_b0;
                        sub_reg    <= pick1 ? i_sub1 : i_sub0;
                    end
                end
                ST_EXEC: result_reg <= i_bus;
                ST_FLAGS: begin
                    carry_reg <= i_flag_c;
                    zero_reg  <= i_flag_z;
                end
                default: ;
            endcase
        end
    end

    assign o_data_a       = data_a_reg;
    assign o_data_b       = data_b_reg;
    assign o_alu_subtract = sub_reg;
    assign o_result       = result_reg;
    assign o_carry        = carry_reg;
    assign o_zero         = zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_req0 = 1'b0, i_req1 = 1'b0;
    logic       i_sub0 = 1'b0, i_sub1 = 1'b0;
    logic [7:0] i_a0 = 8'h00, i_b0 = 8'h00, i_a1 = 8'h00, i_b1 = 8'h00;
    logic [7:0] i_bus;
    logic       i_flag_c, i_flag_z;
    logic [7:0] o_data_a, o_data_b, o_result;
    logic       o_alu_subtract, o_alu_read_n, o_alu_read_flags_n;
    logic       o_grant0, o_grant1, o_done0, o_done1, o_carry, o_zero;

    int total = 0;
    int bad = 0;

    alu_arbiter dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req0(i_req0), .i_req1(i_req1), .i_sub0(i_sub0), .i_sub1(i_sub1),
        .i_a0(i_a0), .i_b0(i_b0), .i_a1(i_a1), .i_b1(i_b1),
        .i_bus(i_bus), .i_flag_c(i_flag_c), .i_flag_z(i_flag_z),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_alu_subtract(o_alu_subtract),
        .o_alu_read_n(o_alu_read_n), .o_alu_read_flags_n(o_alu_read_flags_n),
        .o_grant0(o_grant0), .o_grant1(o_grant1), .o_done0(o_done0), .o_done1(o_done1),
        .o_result(o_result), .o_carry(o_carry), .o_zero(o_zero)
    );

    always #5 i_clk = ~i_clk;

    // Simple ALU: 9-bit add/subtract; carry is bit 8 (borrow on subtract)
    logic [8:0] alu9;
    always_comb begin
        alu9 = o_alu_subtract ? ({1'b0, o_data_a} - {1'b0, o_data_b})
                              : ({1'b0, o_data_a} + {1'b0, o_data_b});
    end
    assign i_bus    = alu9[7:0];
    assign i_flag_c = alu9[8];
    assign i_flag_z = (alu9[7:0] == 8'h00);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_grant_done"}, {o_grant1, o_grant0, o_done1, o_done0}, 4'b0000);
        chk({tag, "_strobes"}, {o_alu_read_n, o_alu_read_flags_n}, 2'b11);
        chk({tag, "_data"}, {o_data_a, o_data_b, o_result}, 24'h000000);
        chk({tag, "_sub_flags"}, {o_alu_subtract, o_carry, o_zero}, 3'b000);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // One full operation with per-phase checks against hand-computed values
    task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] er, input logic ec,
                          input logic ez, input string name);
        logic [1:0] gexp;
        gexp = (who == 0) ? 2'b01 : 2'b10;
        @(negedge i_clk);
        if (who == 0) begin i_req0 = 1'b1; i_a0 = a; i_b0 = b; i_sub0 = sub; end
        else          begin i_req1 = 1'b1; i_a1 = a; i_b1 = b; i_sub1 = sub; end
        @(negedge i_clk);                                   // SETUP
        chk({name, "_setup_grant"}, {o_grant1, o_grant0}, gexp);
        chk({name, "_setup_strobes"}, {o_alu_read_n, o_alu_read_flags_n}, 2'b11);
        chk({name, "_setup_ops"}, {o_data_a, o_data_b, o_alu_subtract}, {a, b, sub});
        chk({name, "_setup_done"}, {o_done1, o_done0}, 2'b00);
        // operand changes after the grant must be ignored
        if (who == 0) begin i_a0 = ~a; i_b0 = ~b; i_sub0 = ~sub; end
        else          begin i_a1 = ~a; i_b1 = ~b; i_sub1 = ~sub; end
        @(negedge i_clk);                                   // EXEC
        chk({name, "_exec_strobes"}, {o_alu_read_n, o_alu_read_flags_n}, 2'b01);
        @(negedge i_clk);                                   // FLAGS
        chk({name, "_flags_strobes"}, {o_alu_read_n, o_alu_read_flags_n}, 2'b10);
        chk({name, "_result"}, o_result, er);
        @(negedge i_clk);                                   // DONE
        chk({name, "_done"}, {o_done1, o_done0}, gexp);
        chk({name, "_done_grant"}, {o_grant1, o_grant0}, gexp);
        chk({name, "_cz"}, {o_carry, o_zero}, {ec, ez});
        chk({name, "_hold_ops"}, {o_data_a, o_data_b, o_alu_subtract}, {a, b, sub});
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        @(negedge i_clk);                                   // IDLE
        chk({name, "_idle"}, {o_grant1, o_grant0, o_done1, o_done0}, 4'b0000);
        chk({name, "_idle_result"}, {o_result, o_carry, o_zero}, {er, ec, ez});
        $display("op %s: req%0d a=%02h b=%02h sub=%0d -> result=%02h c=%0d z=%0d",
                 name, who, a, b, sub, o_result, o_carry, o_zero);
    endtask

    function automatic logic [9:0] alu_exp(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
        logic [8:0] r;
        r = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        return {r[8], (r[7:0] == 8'h00), r[7:0]};
    endfunction

    // Tie test bookkeeping
    int exp_n;
    int exp_seq [4];
    int got_seq [4];
    int got_cyc [4];
    int n_done, conflicts;

    // Random run bookkeeping
    logic [7:0] ra [2];
    logic [7:0] rb [2];
    logic       rs [2];
    logic       g, prev_g, cur, dropped0, dropped1;
    logic [9:0] exp_rnd;
    int phase, ops, nread, nflag, both_low, grant_both, strobe_err, result_err, quiet;

    initial begin
`ifdef ALU_ARBITER_ROUND_ROBIN_EN
        exp_n = 4;
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
        exp_n = 3;
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif

        // Reset state
        do_reset();
        chk_reset_vals("reset");
        $display("reset: grants=%b%b strobes=%b%b result=%02h",
                 o_grant1, o_grant0, o_alu_read_n, o_alu_read_flags_n, o_result);

        // Directed operations
        run_op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "add0");
        run_op(1, 8'h55, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1, "subzero1");
        run_op(1, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0, "addcarry1");
        run_op(0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b1, 1'b0, "subborrow0");
        run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, "addwrap0");

        // Tie: both requests held continuously from reset
        do_reset();
        @(negedge i_clk);
        i_req0 = 1'b1; i_a0 = 8'h01; i_b0 = 8'h02; i_sub0 = 1'b0;
        i_req1 = 1'b1; i_a1 = 8'h03; i_b1 = 8'h04; i_sub1 = 1'b0;
        n_done = 0;
        conflicts = 0;
        for (int cyc = 1; cyc <= 40 && n_done < exp_n; cyc++) begin
            @(negedge i_clk);
            if (o_grant0 && o_grant1) conflicts++;
            if (o_done0 && o_done1) conflicts++;
            if (o_done0 || o_done1) begin
                got_seq[n_done] = o_done1 ? 1 : 0;
                got_cyc[n_done] = cyc;
                $display("tie: done%0d at cycle %0d", got_seq[n_done], cyc);
                n_done++;
            end
        end
        chk("tie_count", n_done, exp_n);
        chk("tie_conflicts", conflicts, 0);
        if (n_done == exp_n) begin
            chk("tie_first_latency", got_cyc[0], 4);
            for (int i = 0; i < exp_n; i++) begin
                chk($sformatf("tie_seq%0d", i), got_seq[i], exp_seq[i]);
                if (i > 0) chk($sformatf("tie_gap%0d", i), got_cyc[i] - got_cyc[i-1], 5);
            end
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        repeat (8) @(negedge i_clk);

        // Reset asserted in the EXEC cycle
        i_req0 = 1'b1; i_a0 = 8'h77; i_b0 = 8'h11; i_sub0 = 1'b0;
        @(negedge i_clk);                                   // SETUP
        @(negedge i_clk);                                   // EXEC
        chk("rst_mid_in_exec", {o_alu_read_n, o_grant0}, 2'b01);
        i_reset = 1'b1;
        i_req0 = 1'b0;
        @(negedge i_clk);
        chk_reset_vals("rst_mid");
        i_reset = 1'b0;
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_clk);
            if (o_done0 || o_done1 || o_grant0 || o_grant1) quiet++;
        end
        chk("rst_mid_no_done", quiet, 0);
        $display("reset mid-op: activity after reset=%0d", quiet);

        // Random run of 20 operations with an independent phase tracker
        prev_g = 1'b0; phase = 0; ops = 0; nread = 0; nflag = 0; cur = 1'b0;
        both_low = 0; grant_both = 0; strobe_err = 0; result_err = 0;
        exp_rnd = '0;
        for (int i = 0; i < 2; i++) begin ra[i] = 8'h00; rb[i] = 8'h00; rs[i] = 1'b0; end
        for (int cyc = 0; cyc < 600 && ops < 20; cyc++) begin
            @(negedge i_clk);
            dropped0 = 1'b0;
            dropped1 = 1'b0;
            g = o_grant0 | o_grant1;
            if (o_grant0 && o_grant1) grant_both++;
            if (!o_alu_read_n && !o_alu_read_flags_n) both_low++;
            if (g) begin
                if (!prev_g) begin
                    phase = 1;
                    cur = o_grant1;
                    exp_rnd = alu_exp(ra[cur], rb[cur], rs[cur]);
                end else begin
                    phase++;
                end
            end else begin
                phase = 0;
            end
            prev_g = g;
            if (!o_alu_read_n) nread++;
            if (!o_alu_read_flags_n) nflag++;
            if (o_alu_read_n !== (phase != 2)) strobe_err++;
            if (o_alu_read_flags_n !== (phase != 3)) strobe_err++;
            if ({o_done1, o_done0} !== ((phase == 4) ? (cur ? 2'b10 : 2'b01) : 2'b00))
                strobe_err++;
            if (phase == 4) begin
                ops++;
                if ({o_carry, o_zero, o_result} !== exp_rnd) result_err++;
                $display("rnd op %0d: req%0d a=%02h b=%02h sub=%0d -> result=%02h c=%0d z=%0d",
                         ops, cur, ra[cur], rb[cur], rs[cur], o_result, o_carry, o_zero);
                if (cur) begin i_req1 = 1'b0; dropped1 = 1'b1; end
                else     begin i_req0 = 1'b0; dropped0 = 1'b1; end
            end
            if (!i_req0 && !dropped0 && $urandom_range(0, 1) == 1) begin
                ra[0] = 8'($urandom); rb[0] = 8'($urandom); rs[0] = 1'($urandom);
                i_a0 = ra[0]; i_b0 = rb[0]; i_sub0 = rs[0]; i_req0 = 1'b1;
            end
            if (!i_req1 && !dropped1 && $urandom_range(0, 1) == 1) begin
                ra[1] = 8'($urandom); rb[1] = 8'($urandom); rs[1] = 1'($urandom);
                i_a1 = ra[1]; i_b1 = rb[1]; i_sub1 = rs[1]; i_req1 = 1'b1;
            end
        end
        i_req0 = 1'b0;
        i_req1 = 1'b0;
        chk("rnd_ops", ops, 20);
        chk("rnd_read_cycles", nread, 20);
        chk("rnd_flag_cycles", nflag, 20);
        chk("rnd_both_strobes_low", both_low, 0);
        chk("rnd_both_grants", grant_both, 0);
        chk("rnd_strobe_timing", strobe_err, 0);
        chk("rnd_results", result_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
